// File: rtl/ssg_emb_sd_adc_pkg.sv
// Shared helpers for the Sinc3 sigma-delta decimator: widths, warmup default,
// log2 clamping and output scaling exponents.
package ssg_emb_sd_adc_pkg;

  localparam int WARMUP_DEFAULT = 3;

  function automatic int acc_width(input int max_log2m);
    return 3 * max_log2m + 1;
  endfunction

  function automatic logic [3:0] clamp_log2(input logic [3:0] req, input int lo, input int hi);
    if (int'(req) < lo) return 4'(lo);
    if (int'(req) > hi) return 4'(hi);
    return req;
  endfunction

  // Midscale of a Sinc3 output at M = 2^k is 2^(3k-1).
  function automatic int midscale_exp(input logic [3:0] k);
    return 3 * int'(k) - 1;
  endfunction

  function automatic int shift_amount(input int out_w, input logic [3:0] k);
    return out_w - 3 * int'(k);
  endfunction

endpackage

// File: rtl/ssg_emb_sd_adc_sinc3_comb.sv
// Three cascaded comb stages of the Sinc3 decimator, advanced only on the
// decimation strobe; c3 is combinational so the output stage can register it.
module ssg_emb_sd_adc_sinc3_comb #(
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic             clear,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] c3
);

  logic [ACC_W-1:0] d1;
  logic [ACC_W-1:0] d2;
  logic [ACC_W-1:0] d3;
  logic [ACC_W-1:0] c1;
  logic [ACC_W-1:0] c2;

  always_comb begin
    c1 = x - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (clear) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (strobe) begin
      d1 <= x;
      d2 <= c1;
      d3 <= c2;
    end
  end

endmodule

// File: rtl/ssg_emb_sd_adc_sinc3.sv
// Sinc3 decimation filter for a 1-bit sigma-delta stream with runtime M = 2^dec_log2.
// Optional sticky overrange detector enabled by SSG_EMB_SD_ADC_OVR_EN.
module ssg_emb_sd_adc_sinc3
  import ssg_emb_sd_adc_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter int MIN_LOG2M = 3,
  parameter int MAX_LOG2M = 8,
  parameter int WARMUP    = WARMUP_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sd_data,
  input  logic [3:0]              dec_log2,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid,
  output logic                    dec_strobe,
  output logic [3:0]              active_log2
`ifdef SSG_EMB_SD_ADC_OVR_EN
  , input  logic [OUT_W-2:0]      ovr_thresh,
  input  logic                    ovr_clr,
  output logic                    ovr
`endif
);

  localparam int ACC_W = acc_width(MAX_LOG2M);
  localparam int CNT_W = MAX_LOG2M;
  localparam int WRM_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam int XW    = ACC_W + OUT_W + 2;
  localparam logic signed [XW-1:0] S_MAX = signed'((XW'(1) << (OUT_W - 1)) - XW'(1));
  localparam logic signed [XW-1:0] S_MIN = ~S_MAX;

  logic [ACC_W-1:0]        i1;
  logic [ACC_W-1:0]        i2;
  logic [ACC_W-1:0]        i3;
  logic [ACC_W-1:0]        c3;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        reload_req;
  logic [CNT_W-1:0]        reload_act;
  logic                    armed;
  logic [WRM_W-1:0]        warm;
  logic [3:0]              req_log2;
  logic                    rate_change;
  logic                    emit;
  logic                    comb_clear;
  logic                    comb_strobe;
  int                      k3;
  int                      sh;
  logic [XW-1:0]           mask;
  logic [XW-1:0]           mid;
  logic signed [XW-1:0]    v;
  logic signed [XW-1:0]    scaled;
  logic signed [OUT_W-1:0] sat;

  assign req_log2    = clamp_log2(dec_log2, MIN_LOG2M, MAX_LOG2M);
  assign reload_req  = CNT_W'((32'd1 << req_log2) - 32'd1);
  assign reload_act  = CNT_W'((32'd1 << active_log2) - 32'd1);
  assign dec_strobe  = enable && armed && (cnt == '0);
  assign rate_change = dec_strobe && (req_log2 != active_log2);
  assign emit        = dec_strobe && !rate_change && (warm == '0);
  assign comb_clear  = !enable || rate_change;
  assign comb_strobe = dec_strobe && !rate_change;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (!enable) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + {{(ACC_W-1){1'b0}}, sd_data};
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // The first enabled cycle arms the counter so the first strobe lands M cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      armed       <= 1'b0;
      warm        <= '0;
      active_log2 <= 4'(MIN_LOG2M);
    end else if (!enable) begin
      cnt   <= '0;
      armed <= 1'b0;
      warm  <= WRM_W'(WARMUP);
    end else if (!armed) begin
      armed       <= 1'b1;
      active_log2 <= req_log2;
      cnt         <= reload_req;
      warm        <= WRM_W'(WARMUP);
    end else if (dec_strobe) begin
      if (rate_change) begin
        active_log2 <= req_log2;
        cnt         <= reload_req;
        warm        <= WRM_W'(WARMUP);
      end else begin
        cnt <= reload_act;
        if (warm != '0) warm <= warm - WRM_W'(1);
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  ssg_emb_sd_adc_sinc3_comb #(
    .ACC_W (ACC_W)
  ) u_comb (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (comb_strobe),
    .clear   (comb_clear),
    .x       (i3),
    .c3      (c3)
  );

  // Only the low 3k+1 bits of c3 are meaningful; the integrators wrap above that.
  always_comb begin
    k3     = 3 * int'(active_log2);
    mask   = (XW'(1) << (k3 + 1)) - XW'(1);
    mid    = XW'(1) << midscale_exp(active_log2);
    v      = signed'({{(XW-ACC_W){1'b0}}, c3} & mask) - signed'(mid);
    sh     = shift_amount(OUT_W, active_log2);
    scaled = (sh >= 0) ? (v <<< sh) : (v >>> (-sh));
    if (scaled > S_MAX)      sat = S_MAX[OUT_W-1:0];
    else if (scaled < S_MIN) sat = S_MIN[OUT_W-1:0];
    else                     sat = scaled[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (emit) begin
        sample       <= sat;
        sample_valid <= 1'b1;
      end
    end
  end

`ifdef SSG_EMB_SD_ADC_OVR_EN
  logic [OUT_W-1:0] mag;
  logic             ovr_hit;

  // Negating the most negative code wraps back to 2^(OUT_W-1), which is the wanted magnitude.
  always_comb begin
    mag     = sat[OUT_W-1] ? $unsigned(-sat) : $unsigned(sat);
    ovr_hit = emit && (mag >= {1'b0, ovr_thresh});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovr <= 1'b0;
    else if (ovr_hit) ovr <= 1'b1;
    else if (ovr_clr) ovr <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ssg_emb_sd_adc_sinc3.sv
// Directed bench for ssg_emb_sd_adc_sinc3 (OUT_W=16); overrange steps compile with SSG_EMB_SD_ADC_OVR_EN.
`timescale 1ns/1ps
module tb_ssg_emb_sd_adc_sinc3;

  localparam int OUT_W = 16;

  logic                    clk      = 1'b0;
  logic                    reset_n  = 1'b0;
  logic                    enable   = 1'b0;
  logic                    sd_data  = 1'b0;
  logic [3:0]              dec_log2 = 4'd4;
  logic signed [OUT_W-1:0] sample;
  logic                    sample_valid;
  logic                    dec_strobe;
  logic [3:0]              active_log2;
`ifdef SSG_EMB_SD_ADC_OVR_EN
  logic [OUT_W-2:0]        ovr_thresh = 15'd30000;
  logic                    ovr_clr    = 1'b0;
  logic                    ovr;
`endif

  int         checks      = 0;
  int         failures    = 0;
  int         cyc         = 0;
  int         last_strobe = 0;
  logic [3:0] pat         = 4'b0000;

  ssg_emb_sd_adc_sinc3 #(
    .OUT_W     (OUT_W),
    .MIN_LOG2M (3),
    .MAX_LOG2M (8),
    .WARMUP    (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sd_data      (sd_data),
    .dec_log2     (dec_log2),
    .sample       (sample),
    .sample_valid (sample_valid),
    .dec_strobe   (dec_strobe),
    .active_log2  (active_log2)
`ifdef SSG_EMB_SD_ADC_OVR_EN
    , .ovr_thresh (ovr_thresh),
    .ovr_clr      (ovr_clr),
    .ovr          (ovr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bitstream repeats the 4-bit pattern LSB first.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      sd_data = pat[ph];
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] dl2, input logic [3:0] p);
    enable   = en;
    dec_log2 = dl2;
    pat      = p;
  endtask

  task automatic waitStrobe(input string tag, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge clk);
      if (dec_strobe === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_strobe_seen"}, 32'(seen), 1);
  endtask

  // mode 0: output suppressed, 1: valid with value, 2: only period checked
  task automatic runStrobes(input string tag, input int n, input int mode,
                            input int exp_sample, input int period);
    bit seen;
    for (int i = 0; i < n; i++) begin
      waitStrobe(tag, seen);
      if (!seen) return;
      if (i > 0) checkOutput({tag, "_period"}, cyc - last_strobe, period);
      last_strobe = cyc;
      @(negedge clk);
      checkOutput({tag, "_strobe_pulse"}, 32'(dec_strobe), 0);
      if (mode == 0) begin
        checkOutput({tag, "_suppressed"}, 32'(sample_valid), 0);
      end else if (mode == 1) begin
        checkOutput({tag, "_valid"}, 32'(sample_valid), 1);
        checkOutput({tag, "_sample"}, sample, exp_sample);
      end
    end
  endtask

  initial begin
    int n_rise;

    applyStimulus(1'b1, 4'd4, 4'b0000);
    repeat (3) @(negedge clk);
    checkOutput("reset_sample", sample, 0);
    checkOutput("reset_valid", 32'(sample_valid), 0);
    checkOutput("reset_strobe", 32'(dec_strobe), 0);
    checkOutput("reset_active", 32'(active_log2), 3);

    reset_n = 1'b1;
    runStrobes("zeros_warmup", 3, 0, 0, 16);
    checkOutput("active_m16", 32'(active_log2), 4);
    runStrobes("zeros", 3, 1, -32768, 16);

    applyStimulus(1'b1, 4'd4, 4'b1111);
    runStrobes("ones_settle", 4, 2, 0, 16);
    runStrobes("ones_clip", 2, 1, 32767, 16);

    applyStimulus(1'b1, 4'd4, 4'b0101);
    runStrobes("alt_settle", 4, 2, 0, 16);
    runStrobes("alt_mid", 2, 1, 0, 16);

    applyStimulus(1'b1, 4'd8, 4'b0111);
    runStrobes("m256_change", 1, 0, 0, 0);
    checkOutput("active_m256", 32'(active_log2), 8);
    runStrobes("m256_warm", 3, 0, 0, 256);
    runStrobes("m256_75pct", 2, 1, 16384, 256);

    applyStimulus(1'b1, 4'd4, 4'b0111);
    runStrobes("m16_change", 1, 0, 0, 0);
    runStrobes("m16_warm", 3, 0, 0, 16);
    runStrobes("m16_75pct", 2, 1, 16384, 16);

    applyStimulus(1'b1, 4'd3, 4'b0001);
    runStrobes("m8_change", 1, 0, 0, 0);
    checkOutput("active_m8", 32'(active_log2), 3);
    runStrobes("m8_warm", 3, 0, 0, 8);
    runStrobes("m8_25pct", 2, 1, -16384, 8);

    applyStimulus(1'b1, 4'd15, 4'b0001);
    runStrobes("clamp_hi_change", 1, 0, 0, 0);
    checkOutput("clamp_hi_active", 32'(active_log2), 8);
    applyStimulus(1'b1, 4'd0, 4'b0001);
    runStrobes("clamp_lo_change", 1, 0, 0, 0);
    checkOutput("clamp_lo_active", 32'(active_log2), 3);
    runStrobes("clamp_lo_warm", 3, 0, 0, 8);
    runStrobes("clamp_lo_val", 1, 1, -16384, 8);

    applyStimulus(1'b0, 4'd0, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("disabled_strobe", 32'(dec_strobe), 0);
      checkOutput("disabled_valid", 32'(sample_valid), 0);
    end
    checkOutput("disabled_hold", sample, -16384);
    applyStimulus(1'b1, 4'd0, 4'b0001);
    n_rise = 0;
    do begin
      @(negedge clk);
      n_rise++;
    end while (dec_strobe !== 1'b1 && n_rise < 20);
    checkOutput("enable_rise_latency", n_rise, 8);
    last_strobe = cyc;
    @(negedge clk);
    checkOutput("enable_rise_suppressed", 32'(sample_valid), 0);
    runStrobes("rewarm", 2, 0, 0, 8);
    runStrobes("after_enable", 1, 1, -16384, 8);

    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_sample", sample, 0);
    checkOutput("async_reset_valid", 32'(sample_valid), 0);
    checkOutput("async_reset_strobe", 32'(dec_strobe), 0);
    checkOutput("async_reset_active", 32'(active_log2), 3);

`ifdef SSG_EMB_SD_ADC_OVR_EN
    begin
      bit seen;
      @(negedge clk);
      checkOutput("ovr_reset", 32'(ovr), 0);
      applyStimulus(1'b1, 4'd4, 4'b1111);
      reset_n = 1'b1;
      runStrobes("ovr_warm", 3, 0, 0, 16);
      waitStrobe("ovr_first", seen);
      @(negedge clk);
      checkOutput("ovr_first_valid", 32'(sample_valid), 1);
      checkOutput("ovr_first_sample", sample, 32767);
      checkOutput("ovr_set", 32'(ovr), 1);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      checkOutput("ovr_cleared", 32'(ovr), 0);
      waitStrobe("ovr_race", seen);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      checkOutput("ovr_race_valid", 32'(sample_valid), 1);
      checkOutput("ovr_set_wins", 32'(ovr), 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssg_emb_sd_adc_sinc3.md
Name: ssg_emb_sd_adc_sinc3

Overview:
Complete parametrised Sinc3 decimation filter for one 1-bit sigma-delta modulator stream. It contains the three integrators, the decimation counter, the three comb stages, midscale removal, and output scaling and saturation. Decimation ratio M = 2^dec_log2 is selectable at runtime. Output is a signed OUT_W sample with a valid strobe. It sits between the modulator data input and the current-measurement/register interface of the ADC subsystem.

Parameters:
OUT_W, 16, signed output sample width (8..24)
MIN_LOG2M, 3, smallest legal dec_log2 (M=8)
MAX_LOG2M, 8, largest legal dec_log2 (M=256); integrator/comb width ACC_W = 3*MAX_LOG2M+1
WARMUP, 3, decimated outputs suppressed after reset, enable rise or rate change

Ports:
clk  in  1  ADC/modulator clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  filter run; low clears datapath and restarts warmup
sd_data  in  1  modulator bitstream, sampled every clk
dec_log2  in  4  requested log2(M); values outside [MIN_LOG2M,MAX_LOG2M] are clamped into range
sample  out  OUT_W  signed two's-complement filtered sample
sample_valid  out  1  one-cycle pulse, sample updated same cycle
dec_strobe  out  1  one-cycle pulse at each decimation boundary (also pulses during warmup)
active_log2  out  4  dec_log2 currently in effect

Behaviour:
- Reset: integrators, combs, counter, warmup count, sample = 0; sample_valid = 0; dec_strobe = 0; active_log2 = MIN_LOG2M.
- Integrators (ACC_W bits, modular wrap, no saturation), registered each clk while enable=1: i1 += sd_data; i2 += i1; i3 += i2.
- Decimation counter counts M-1 down to 0. dec_strobe is asserted in the cycle the counter equals 0; the counter then reloads M-1.
- On dec_strobe: d0<=i3; c1=d0-d1; c2=c1-d2; c3=c2-d3 (ACC_W modular). Comb registers update. c3 is captured into the output stage.
- Output stage, one cycle after dec_strobe:
  - k = active_log2.
  - v = c3[3k:0] - 2^(3k-1), taken as a signed value in [-2^(3k-1), +2^(3k-1)].
  - s = OUT_W-3k. Left-shift v by s if s>=0; otherwise arithmetic-shift right by -s (truncate toward -inf).
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; only positive full scale can clip.
  - sample updated; sample_valid=1 unless the warmup counter is nonzero. A suppressed output decrements the counter and leaves sample unchanged.
- Latency: sample_valid occurs exactly 1 clk after its dec_strobe.
- Rate change:
  - dec_log2 (clamped) is compared at every dec_strobe.
  - If it differs, it is latched into active_log2 on that strobe. That strobe's output is discarded. Comb registers are cleared, the counter reloads with the new M-1, and warmup restarts at WARMUP.
  - Integrators keep running.
- enable low: integrators, combs and counter are held at 0. dec_strobe and sample_valid stay 0. sample holds its last value. The warmup counter is set to WARMUP.
- enable rise: the first dec_strobe occurs M cycles later.
- Reset asserted mid-operation returns all state to reset values immediately.

Optional Feature:
Macro SSG_EMB_SD_ADC_OVR_EN.
- Defined:
  - Adds ports ovr_thresh in OUT_W-1 (unsigned magnitude), ovr_clr in 1, and ovr out 1.
  - ovr sets in the sample_valid cycle if |sample| >= ovr_thresh, where |-2^(OUT_W-1)| is treated as 2^(OUT_W-1).
  - ovr is sticky until ovr_clr. If set and clear occur in the same cycle, set wins. ovr resets to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ssg_emb_sd_adc_pkg: ACC_W function, WARMUP default, log2-clamp function, and the midscale/shift-amount helper functions.
- One sub-module, ssg_emb_sd_adc_sinc3_comb: the three comb stages plus clear. It is clocked by dec_strobe as an enable.
- Integrators, counter, output scaler and warmup logic stay in the top.

Test Plan:
- OUT_W=16, dec_log2=4, sd_data all 0: first 3 strobes give no valid; all subsequent samples = -32768, each valid exactly 1 clk after dec_strobe, strobe period 16 clk.
- Same config, sd_data all 1: samples = 32767 (clipped from +32768). Alternating 0101: samples = 0.
- dec_log2=8, OUT_W=16, constant 75% ones density (pattern 1110): samples = 16384 (right shift 8). Strobe period 256.
- Change dec_log2 4->3 mid-run: change takes effect at the next strobe. active_log2=3, 3 outputs suppressed, strobe period becomes 8, steady value is correct for M=8.
- dec_log2=15 and dec_log2=0: active_log2 = 8 and 3 respectively. Toggle enable low for 5 clk: no strobes, sample held, warmup restarts. Assert reset_n low mid-period: all outputs = 0 asynchronously.
- With SSG_EMB_SD_ADC_OVR_EN, ovr_thresh=30000, all-ones input: ovr sets on the first valid sample. ovr_clr pulsed together with a set event leaves ovr=1.
